c2c_wbuf: RTL and testbench

C2C_WBUF -- requirements
Module: c2c_wbuf

---
 rtl/c2c_wbuf.sv | 109 ++++++++++
 tb/tb_c2c_wbuf.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/c2c_wbuf.sv
// Posted-write buffer between a core slave port and a cache master port.
// Optional macro C2C_WBUF_MERGE_EN folds same-word writes into the tail entry.
module c2c_wbuf #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     c_we,
  input  logic [XLEN/8-1:0]        c_sel,
  input  logic [XLEN-1:0]          c_addr,
  input  logic [XLEN-1:0]          c_data,
  output logic                     c_ack,
  output logic                     m_we,
  output logic [XLEN/8-1:0]        m_sel,
  output logic [XLEN-1:0]          m_addr,
  output logic [XLEN-1:0]          m_data,
  input  logic                     m_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int SW = XLEN / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [XLEN-1:0] addr_mem_r [DEPTH];
  logic [SW-1:0]   sel_mem_r  [DEPTH];
  logic [XLEN-1:0] data_mem_r [DEPTH];

  logic [AW-1:0] wptr_r;
  logic [AW-1:0] rptr_r;
  logic [CW-1:0] count_r;
  logic [AW-1:0] tail_ptr_s;
  logic          merge_hit_s;
  logic          full_s;
  logic          merge_s;
  logic          new_entry_s;
  logic          pop_s;

  assign tail_ptr_s = wptr_r - AW'(1);

`ifdef C2C_WBUF_MERGE_EN
  localparam int LSB = $clog2(SW);

  // Tail is never the head while two or more entries are queued, so the head stays untouched.
  always_comb begin
    merge_hit_s = (count_r >= CW'(2)) &&
                  (c_addr[XLEN-1:LSB] == addr_mem_r[tail_ptr_s][XLEN-1:LSB]);
  end
`else
  assign merge_hit_s = 1'b0;
`endif

  // Core handshake and push/pop decode.
  always_comb begin
    full_s      = (count_r == FULL_C);
    c_ack       = c_we && (!full_s || merge_hit_s);
    merge_s     = c_ack && merge_hit_s;
    new_entry_s = c_ack && !merge_hit_s;
    pop_s       = m_we && m_ack;
  end

  assign count  = count_r;
  assign empty  = (count_r == CW'(0));
  assign m_we   = !empty;
  assign m_addr = addr_mem_r[rptr_r];
  assign m_sel  = sel_mem_r[rptr_r];
  assign m_data = data_mem_r[rptr_r];

  // Entry storage; contents are only visible through the pointers, so no reset is needed.
  always_ff @(posedge clk) begin
    if (new_entry_s) begin
      addr_mem_r[wptr_r] <= c_addr;
      sel_mem_r[wptr_r]  <= c_sel;
      data_mem_r[wptr_r] <= c_data;
    end else if (merge_s) begin
      sel_mem_r[tail_ptr_s] <= sel_mem_r[tail_ptr_s] | c_sel;
      for (int b = 0; b < SW; b++) begin
        if (c_sel[b]) begin
          data_mem_r[tail_ptr_s][8*b +: 8] <= c_data[8*b +: 8];
        end
      end
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r  <= AW'(0);
      rptr_r  <= AW'(0);
      count_r <= CW'(0);
    end else begin
      if (new_entry_s) begin
        wptr_r <= wptr_r + AW'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + AW'(1);
      end
      case ({new_entry_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_c2c_wbuf.sv
// Bench for c2c_wbuf: queue-based reference model, directed scenarios, random traffic.
module tb_c2c_wbuf;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
`ifdef C2C_WBUF_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        c_we;
  logic [3:0]  c_sel;
  logic [31:0] c_addr;
  logic [31:0] c_data;
  logic        c_ack;
  logic        m_we;
  logic [3:0]  m_sel;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  logic        m_ack;
  logic [2:0]  count;
  logic        empty;

  c2c_wbuf #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .c_we(c_we), .c_sel(c_sel), .c_addr(c_addr),
    .c_data(c_data), .c_ack(c_ack), .m_we(m_we), .m_sel(m_sel),
    .m_addr(m_addr), .m_data(m_data), .m_ack(m_ack), .count(count),
    .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit model_hit();
    if (!MERGE || q.size() < 2) return 1'b0;
    return (c_addr >> 2) == (q[q.size()-1].addr >> 2);
  endfunction

  // Compare every DUT output against the queue model.
  task automatic compare();
    bit exp_ack;
    exp_ack = c_we && (q.size() < DEPTH || model_hit());
    chk("c_ack", 32'(c_ack), 32'(exp_ack));
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("m_we", 32'(m_we), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("m_addr", m_addr, q[0].addr);
      chk("m_sel", 32'(m_sel), 32'(q[0].sel));
      chk("m_data", m_data, q[0].data);
    end
  endtask

  task automatic step(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                      input logic [31:0] data, input logic ack, output logic ack_seen);
    bit   acc, hit, pop;
    ent_t t;
    @(negedge clk);
    c_we = we; c_sel = sel; c_addr = addr; c_data = data; m_ack = ack;
    #1;
    compare();
    ack_seen = c_ack;
    hit = model_hit();
    acc = we && (q.size() < DEPTH || hit);
    pop = ack && (q.size() != 0);
    @(posedge clk);
    if (acc && hit) begin
      t = q[q.size()-1];
      t.sel = t.sel | sel;
      for (int b = 0; b < 4; b++) if (sel[b]) t.data[8*b +: 8] = data[8*b +: 8];
      q[q.size()-1] = t;
    end else if (acc) begin
      t.addr = addr; t.sel = sel; t.data = data;
      q.push_back(t);
    end
    if (pop) void'(q.pop_front());
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < 8; i++) step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, a);
  endtask

  initial begin
    logic a;
    rst = 1'b1; c_we = 1'b0; c_sel = 4'h0; c_addr = 32'h0; c_data = 32'h0; m_ack = 1'b0;
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_c_ack_idle", 32'(c_ack), 32'd0);
    c_we = 1'b1;
    #1;
    chk("rst_c_ack_we", 32'(c_ack), 32'd1);
    c_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Single write, then hold with m_ack low.
    step(1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 1'b0, a);
    chk("w1_ack", 32'(a), 32'd1);
    #1;
    chk("w1_m_we", 32'(m_we), 32'd1);
    chk("w1_addr", m_addr, 32'h100);
    chk("w1_data", m_data, 32'hDEADBEEF);
    chk("w1_count", 32'(count), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, a);
    chk("w1_hold_addr", m_addr, 32'h100);
    drain();

    // Fill, refuse the fifth, accept it after one drain.
    for (int i = 1; i <= 4; i++) step(1'b1, 4'hF, 32'(i * 16), 32'(i), 1'b0, a);
    #1;
    chk("full_count", 32'(count), 32'd4);
    chk("full_head", m_addr, 32'h10);
    step(1'b1, 4'hF, 32'h50, 32'd5, 1'b0, a);
    chk("full_refuse", 32'(a), 32'd0);
    step(1'b1, 4'hF, 32'h50, 32'd5, 1'b1, a);
    chk("full_pop_refuse", 32'(a), 32'd0);
    step(1'b1, 4'hF, 32'h50, 32'd5, 1'b0, a);
    chk("fifth_ack", 32'(a), 32'd1);
    for (int i = 2; i <= 5; i++) begin
      #1;
      chk("order_addr", m_addr, 32'(i * 16));
      step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, a);
    end

    // Simultaneous push/pop keeps count; ten pairs wrap the pointers.
    step(1'b1, 4'hF, 32'h60, 32'h6, 1'b0, a);
    step(1'b1, 4'hF, 32'h70, 32'h7, 1'b0, a);
    step(1'b1, 4'hF, 32'h80, 32'h8, 1'b1, a);
    #1;
    chk("pp_count", 32'(count), 32'd2);
    for (int i = 0; i < 10; i++) step(1'b1, 4'(i), 32'(32'h1000 + i * 16), $urandom, 1'b1, a);
    #1;
    chk("pp_wrap_count", 32'(count), 32'd2);
    drain();

    // Merge scenario.
    step(1'b1, 4'hF, 32'h200, 32'h11111111, 1'b0, a);
    step(1'b1, 4'h3, 32'h300, 32'h0000AAAA, 1'b0, a);
    step(1'b1, 4'hC, 32'h302, 32'hBBBB0000, 1'b0, a);
    #1;
    chk("mg_count", 32'(count), MERGE ? 32'd2 : 32'd3);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, a);
    #1;
    chk("mg_sel", 32'(m_sel), MERGE ? 32'hF : 32'h3);
    chk("mg_data", m_data, MERGE ? 32'hBBBBAAAA : 32'h0000AAAA);
    drain();

    // Head is never merged.
    step(1'b1, 4'hF, 32'h400, 32'h44444444, 1'b0, a);
    step(1'b1, 4'h1, 32'h400, 32'h000000EE, 1'b0, a);
    #1;
    chk("hd_count", 32'(count), 32'd2);
    chk("hd_data", m_data, 32'h44444444);
    drain();

    // Asynchronous reset mid-traffic.
    for (int i = 0; i < 3; i++) step(1'b1, 4'hF, 32'(32'h500 + i * 16), 32'(i), 1'b0, a);
    @(negedge clk);
    c_we = 1'b1; c_addr = 32'h530; c_sel = 4'hF; c_data = 32'h3;
    #2 rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_m_we", 32'(m_we), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_c_ack", 32'(c_ack), 32'd1);
    q.delete();
    @(negedge clk);
    rst = 1'b0; c_we = 1'b0;
    step(1'b1, 4'hF, 32'h600, 32'h66666666, 1'b0, a);
    #1;
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_addr", m_addr, 32'h600);
    drain();

    // Random traffic over a few words to exercise merging and wrap.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 3) != 0, 4'($urandom), 32'(32'h1000 + ($urandom % 6) * 2),
           $urandom, ($urandom % 2) == 1, a);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
